// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus of the
// boot-time instruction-memory loader.
//
// Signals:
//   in_valid / in_data[7:0] / in_last / in_ready : upstream byte handshake
//   wr_en / wr_addr[ADDR_W-1:0] / wr_data[7:0]   : instruction-memory byte write
//
// Modports:
//   slave  - the loader: consumes the stream, drives the memory write port
//   master - the image source / memory side (e.g. a testbench)
interface imem_loader_if #(
  parameter int ADDR_W = 5
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader in front of a byte-wide instruction memory.
// Takes a byte stream over valid/ready, writes it from address 0 upwards, and
// releases the processor (run=1) only once a complete, word-aligned image has
// been written. Overflowing or misaligned images end in a sticky error.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             one-cycle pulse, begins (or restarts) a load
//   bus (slave)       in_valid/in_data/in_last/in_ready stream input,
//                     wr_en/wr_addr/wr_data instruction-memory write port
//   busy              load in progress (LOAD or CHECK)
//   run               image valid, processor may fetch from pc=0
//   err               load failed; sticky until start or rst
//   byte_count        bytes written in the current/last load
//
// Build option: define IMEM_LOADER_CKSUM_EN to require a trailing checksum
// byte (sum of image bytes mod 256) before the image is accepted.
module imem_loader #(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            busy,
  output logic            run,
  output logic            err,
  output logic [ADDR_W:0] byte_count
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam logic [2:0] ST_CHECK = 3'd2;
`endif
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  // Where a correctly terminated, aligned image goes next.
`ifdef IMEM_LOADER_CKSUM_EN
  localparam logic [2:0] ST_IMAGE_DONE = ST_CHECK;
`else
  localparam logic [2:0] ST_IMAGE_DONE = ST_RUN;
`endif

  localparam logic [ADDR_W:0]   MEM_BYTES_C = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W-1:0] PTR_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE     = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic              busy_nxt_s;
  logic              busy_r;
  logic              run_r;
  logic              err_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_inc_s;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        wr_data_r;
  logic              hs_s;
  logic              load_hs_s;

`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        acc_r;

  function automatic logic [7:0] cksum_add(input logic [7:0] acc,
                                           input logic [7:0] b);
    cksum_add = acc + b;
  endfunction
`endif

  // busy_r mirrors "next state is LOAD/CHECK", so ready never depends on in_valid.
  assign hs_s        = bus.in_valid & busy_r;
  assign load_hs_s   = hs_s & (state_r == ST_LOAD);
  assign count_inc_s = count_r + CNT_ONE;

`ifdef IMEM_LOADER_CKSUM_EN
  assign busy_nxt_s = (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_CHECK);
`else
  assign busy_nxt_s = (state_nxt_s == ST_LOAD);
`endif

  // Next-state decode of the load sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_LOAD;
        else       state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (start) begin
          state_nxt_s = ST_LOAD;
        end else if (hs_s) begin
          if (bus.in_last) begin
            if (count_inc_s[1:0] == 2'b00) state_nxt_s = ST_IMAGE_DONE;
            else                           state_nxt_s = ST_ERROR;
          end else if (count_inc_s == MEM_BYTES_C) begin
            // Memory full and still no end marker: image too large.
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      ST_CHECK: begin
        if (start) begin
          state_nxt_s = ST_LOAD;
        end else if (hs_s) begin
          if (bus.in_data == acc_r) state_nxt_s = ST_RUN;
          else                      state_nxt_s = ST_ERROR;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
`endif
      ST_RUN, ST_ERROR: begin
        if (start) state_nxt_s = ST_LOAD;
        else       state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      run_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      // run waits one cycle in RUN so the final write strobe lands first.
      run_r   <= (state_r == ST_RUN) && (state_nxt_s == ST_RUN);
      err_r   <= (state_nxt_s == ST_ERROR);
    end
  end

  // Write pointer, byte count and the registered memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r     <= {ADDR_W{1'b0}};
      count_r   <= {(ADDR_W+1){1'b0}};
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= 8'h00;
    end else if (start) begin
      // start outranks a simultaneous handshake: that byte is dropped.
      ptr_r   <= {ADDR_W{1'b0}};
      count_r <= {(ADDR_W+1){1'b0}};
      wr_en_r <= 1'b0;
    end else if (load_hs_s) begin
      wr_en_r   <= 1'b1;
      wr_addr_r <= ptr_r;
      wr_data_r <= bus.in_data;
      ptr_r     <= ptr_r + PTR_ONE;
      count_r   <= count_inc_s;
    end else begin
      wr_en_r <= 1'b0;
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  // Running mod-256 sum of the image bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= 8'h00;
    end else if (start) begin
      acc_r <= 8'h00;
    end else if (load_hs_s) begin
      acc_r <= cksum_add(acc_r, bus.in_data);
    end else begin
      acc_r <= acc_r;
    end
  end
`endif

  assign bus.in_ready = busy_r;
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign busy         = busy_r;
  assign run          = run_r;
  assign err          = err_r;
  assign byte_count   = count_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader. Expected memory writes
// and final load status are predicted from the image contents and the load
// rules; a per-cycle monitor checks every write strobe against that prediction.
module tb_imem_loader;
  localparam int ADDR_W    = 5;
  localparam int MEM_BYTES = 32;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            run;
  logic            err;
  logic [ADDR_W:0] byte_count;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .run(run), .err(err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] img [0:39];
  int         exp_addr_q [$];
  logic [7:0] exp_data_q [$];
  int         cur_streak  = 0;
  int         last_streak = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] img_sum(input int n);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < n; k++) s = s + img[k];
    return s;
  endfunction

  // Outcome of loading img[0..n-1] (plus optional checksum byte).
  function automatic void predict(input int n, input bit last, input bit add_ck,
                                  input logic [7:0] ck, output bit r, output bit e,
                                  output int cnt, output int nw);
    if (n > MEM_BYTES || (!last && n >= MEM_BYTES)) begin
      nw = MEM_BYTES; cnt = MEM_BYTES; e = 1'b1; r = 1'b0;
    end else if (!last) begin
      nw = n; cnt = n; e = 1'b0; r = 1'b0;
    end else begin
      nw = n; cnt = n;
      if (n % 4 != 0)  e = 1'b1;
      else if (add_ck) e = (ck != img_sum(n));
      else             e = 1'b0;
      r = !e;
    end
  endfunction

  // Monitor: every write strobe must match the next predicted write.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      cur_streak++;
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_wr_en", {31'd0, bus.wr_en}, 32'd0);
      end else begin
        chk("wr_addr", {27'd0, bus.wr_addr}, exp_addr_q.pop_front());
        chk("wr_data", {24'd0, bus.wr_data}, {24'd0, exp_data_q.pop_front()});
      end
    end else begin
      if (cur_streak != 0) last_streak = cur_streak;
      cur_streak = 0;
    end
    chk("in_ready_eq_busy", {31'd0, bus.in_ready}, {31'd0, busy});
    chk("run_err_exclusive", {31'd0, run & err}, 32'd0);
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_run_low", {31'd0, run}, 32'd0);
    chk("start_err_clr", {31'd0, err}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_count_clr", {26'd0, byte_count}, 32'd0);
  endtask

  // Drive image body from the current negedge (LOAD already entered).
  task automatic send_body(input int n, input bit with_last, input bit add_ck,
                           input logic [7:0] ck);
    bit pr, pe;
    int pc, pw, total, i;
    predict(n, with_last, add_ck, ck, pr, pe, pc, pw);
    for (int k = 0; k < pw; k++) begin
      exp_addr_q.push_back(k);
      exp_data_q.push_back(img[k]);
    end
    total = n + (add_ck ? 1 : 0);
    i = 0;
    while (i < total && bus.in_ready === 1'b1) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i < n) ? img[i] : ck;
      bus.in_last  = with_last && (i == n - 1);
      @(negedge clk);
      i++;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = 8'h00;
    chk("run_low_with_last_strobe", {31'd0, run}, 32'd0);
    @(negedge clk);
    chk("run_after_strobe", {31'd0, run}, {31'd0, pr});
    @(negedge clk);
    chk("final_run", {31'd0, run}, {31'd0, pr});
    chk("final_err", {31'd0, err}, {31'd0, pe});
    chk("final_count", {26'd0, byte_count}, pc);
    chk("final_busy", {31'd0, busy}, 32'd0);
    chk("final_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("pending_writes", exp_addr_q.size(), 32'd0);
    chk("burst_len", last_streak, pw);
  endtask

  task automatic load_image(input int n, input bit with_last, input bit add_ck,
                            input logic [7:0] ck);
    pulse_start();
    send_body(n, with_last, add_ck, ck);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit mr, me;
    int mc, mw;
    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("rst_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
    chk("rst_count", {26'd0, byte_count}, 32'd0);
    rst = 1'b0;

    // Basic load.
    img[0] = 8'h20; img[1] = 8'h04; img[2] = 8'h00; img[3] = 8'h05;
    img[4] = 8'h00; img[5] = 8'h85; img[6] = 8'h30; img[7] = 8'h20;
    chk("model_sum_basic", {24'd0, img_sum(8)}, 32'h0000_00FE);
    predict(6, 1'b1, 1'b0, 8'h00, mr, me, mc, mw);
    chk("model_misaligned_err", {31'd0, me}, 32'd1);
    load_image(8, 1'b1, CK, img_sum(8));

    // Restart from RUN with a fresh 4-byte image (full throughput).
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    load_image(4, 1'b1, CK, img_sum(4));

    // Misaligned length.
    for (int k = 0; k < 6; k++) img[k] = 8'hA0 + 8'(k);
    load_image(6, 1'b1, 1'b0, 8'h00);

    // Overflow: no end marker.
    for (int k = 0; k < 33; k++) img[k] = 8'(k * 7 + 3);
    predict(33, 1'b0, 1'b0, 8'h00, mr, me, mc, mw);
    chk("model_overflow_writes", mw, 32'd32);
    load_image(33, 1'b0, 1'b0, 8'h00);

    // start together with a handshake: byte discarded, load restarts at 0.
    exp_addr_q.push_back(0); exp_data_q.push_back(img[0]);
    exp_addr_q.push_back(1); exp_data_q.push_back(img[1]);
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1; bus.in_data = img[k]; bus.in_last = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1; bus.in_data = 8'hEE; bus.in_last = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("restart_count_clr", {26'd0, byte_count}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_pending", exp_addr_q.size(), 32'd0);
    send_body(4, 1'b1, CK, img_sum(4));

    // Reset mid-load after 3 bytes; in_valid stays high afterwards.
    for (int k = 0; k < 3; k++) begin
      exp_addr_q.push_back(k); exp_data_q.push_back(img[k]);
    end
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.in_data = img[k]; bus.in_last = 1'b0;
      @(negedge clk);
    end
    bus.in_data = 8'h99; rst = 1'b1;
    @(negedge clk);
    chk("midrst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_run", {31'd0, run}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_count", {26'd0, byte_count}, 32'd0);
    chk("midrst_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midrst_pending", exp_addr_q.size(), 32'd0);
    chk("midrst_idle_busy", {31'd0, busy}, 32'd0);

`ifdef IMEM_LOADER_CKSUM_EN
    img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
    chk("model_sum_small", {24'd0, img_sum(4)}, 32'h0000_000A);
    load_image(4, 1'b1, 1'b1, 8'h0A);
    load_image(4, 1'b1, 1'b1, 8'h0B);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
